key_press_gen: RTL
==================

KEY_PRESS_GEN -- requirements
Module: key_press_gen

Interface
REQ-001 Parameter N, default 2: number of emulated active-low key lines.
REQ-002 Parameter SEL_W, default 1: width of key_sel; SHALL satisfy 2**SEL_W >= N.
REQ-003 Parameter HOLD_W, default 18: width of hold_len.
REQ-004 Parameter GAP_CYC, default 16: released-gap length, in cycles, after each press.
REQ-005 Parameter BOUNCE_CYC, default 16: chatter length, in cycles, per edge when bounce is enabled.
REQ-006 clk  input  1  system clock; all logic on posedge clk.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 req  input  1  press request, qualified by ready.
REQ-009 key_sel  input  SEL_W  index of the key line to press; sampled on acceptance.
REQ-010 hold_len  input  HOLD_W  press duration in cycles; sampled on acceptance.
REQ-011 ready  output  1  high when a request can be accepted.
REQ-012 done  output  1  one-cycle pulse marking press-sequence completion.
REQ-013 key_out  output  N  active-low key lines; idle level is all ones.

Function
REQ-014 FSM states: IDLE, BOUNCE_IN, HOLD, BOUNCE_OUT, GAP; ready SHALL be 1 only in IDLE.
REQ-015 Acceptance: req=1 while ready=1 at a posedge; key_sel and hold_len latched at that edge.
REQ-016 Requests while ready=0 SHALL be ignored, with no queuing.
REQ-017 Accepted request with key_sel >= N: FSM stays in IDLE, key_out unchanged, no done pulse.
REQ-018 hold_len = 0 SHALL be treated as 1.
REQ-019 From IDLE, an accepted request moves the FSM to BOUNCE_IN when bounce is enabled, else to HOLD.
REQ-020 HOLD: key_out[sel] = 0 for exactly the latched hold_len cycles, then BOUNCE_OUT (bounce enabled) or GAP.
REQ-021 GAP: key_out all ones for exactly GAP_CYC cycles.
REQ-022 done = 1 during the last GAP cycle only; the FSM returns to IDLE on the following edge, so ready = 1 one cycle after done.
REQ-023 key_out SHALL be registered and never glitch.
REQ-024 Only the selected bit may change during a sequence; all other bits stay 1.
REQ-025 Bounce-disabled latency: key_out[sel] falls on the first edge after acceptance.
REQ-026 Bounce-disabled request-to-done: hold_len + GAP_CYC cycles.
REQ-027 Internal down-counter of width max(HOLD_W, 16); a count of 0 SHALL never wrap or underflow.

Reset
REQ-028 On rst=1 at a posedge: state = IDLE, key_out = all ones, done = 0, ready = 1 from the next cycle, counter = 0.
REQ-029 Reset mid-sequence aborts the sequence: the line releases on that edge and no done pulse is issued.
REQ-030 rst has priority over req at the same edge.

Configuration
REQ-031 Macro KEY_PRESS_GEN_BOUNCE_EN defined: BOUNCE_IN and BOUNCE_OUT each last BOUNCE_CYC cycles.
REQ-032 Bounce chatter: key_out[sel] = bit 0 of a 16-bit Fibonacci LFSR (taps 16,14,13,11).
REQ-033 LFSR seeded 16'hACE1 on reset and advancing every cycle.
REQ-034 Final cycle of each bounce state is forced to the settled level: 0 for BOUNCE_IN, 1 for BOUNCE_OUT.
REQ-035 With the macro, request-to-done = 2*BOUNCE_CYC + hold_len + GAP_CYC cycles.
REQ-036 Macro undefined: bounce states and LFSR are not synthesised; the FSM goes IDLE -> HOLD -> GAP.

Verification
REQ-037 No macro, N=2, req with key_sel=1, hold_len=100 -> key_out=2'b01 for exactly 100 cycles from the edge after acceptance; done 116 cycles after acceptance; ready high 117 cycles after.
REQ-038 hold_len=0, key_sel=0 -> key_out=2'b10 for exactly 1 cycle; done after 17 cycles.
REQ-039 req held high throughout a sequence -> exactly one sequence, and the next acceptance occurs on the first ready=1 edge.
REQ-040 rst pulsed at cycle 50 of a 100-cycle hold -> key_out=2'b11 on that edge, no done pulse, ready=1 the next cycle.
REQ-041 With KEY_PRESS_GEN_BOUNCE_EN, hold_len=1000 -> 16 chatter cycles ending low, 1000 low cycles, 16 chatter cycles ending high, done 1048 cycles after acceptance.
REQ-042 With KEY_PRESS_GEN_BOUNCE_EN, output looped back through the debounce block -> exactly one key_pulse per press.
REQ-043 key_sel=3 with N=2 and SEL_W=2 -> key_out stays 2'b11, no done, ready stays 1.

Source files
------------

// File: rtl/key_press_gen.sv
// key_press_gen -- emulates presses on a bank of active-low key lines.
//
// A request (req while ready) latches key_sel and hold_len. The selected
// line is then driven low for hold_len cycles (0 counts as 1). A released gap
// of GAP_CYC cycles follows, and done pulses in the last gap cycle. Requests
// made while busy are dropped. A key_sel outside the N lines is accepted but
// has no effect.
//
// Optional feature: define KEY_PRESS_GEN_BOUNCE_EN to wrap the hold phase in
// BOUNCE_CYC cycles of LFSR chatter on each edge. Without it, the bounce
// states and the LFSR are not built.
//
// Ports:
//   clk      in   system clock, all logic on posedge
//   rst      in   synchronous active-high reset
//   req      in   press request, qualified by ready
//   key_sel  in   [SEL_W]  line index, sampled on acceptance
//   hold_len in   [HOLD_W] press duration in cycles, sampled on acceptance
//   ready    out  request can be accepted
//   done     out  one-cycle pulse at sequence completion
//   key_out  out  [N] registered active-low key lines, idle all ones
module key_press_gen #(
  parameter int N          = 2,
  parameter int SEL_W      = 1,
  parameter int HOLD_W     = 18,
  parameter int GAP_CYC    = 16,
  parameter int BOUNCE_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic [SEL_W-1:0]  key_sel,
  input  logic [HOLD_W-1:0] hold_len,
  output logic              ready,
  output logic              done,
  output logic [N-1:0]      key_out
);

  localparam int CNT_W = (HOLD_W > 16) ? HOLD_W : 16;
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'((GAP_CYC < 1) ? 1 : GAP_CYC);
  localparam logic [31:0] N_U = 32'(N);

`ifdef KEY_PRESS_GEN_BOUNCE_EN
  localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'((BOUNCE_CYC < 1) ? 1 : BOUNCE_CYC);
  typedef enum logic [2:0] {
    IDLE = 3'd0, HOLD = 3'd1, GAP = 3'd2, BOUNCE_IN = 3'd3, BOUNCE_OUT = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE = 3'd0, HOLD = 3'd1, GAP = 3'd2
  } state_t;
`endif

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [N-1:0]       key_out_q, key_out_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   hold_load;
  logic               level;   // level for the selected line next cycle (1 = released)
  logic               last;    // current phase ends at this edge
  logic               accept;

`ifdef KEY_PRESS_GEN_BOUNCE_EN
  logic [15:0]        lfsr_q, lfsr_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
`endif

  // ready is held low during the done cycle so it rises one cycle after done.
  assign ready   = (state_q == IDLE) && !done_q;
  assign done    = done_q;
  assign key_out = key_out_q;

  assign accept    = req && ready && (32'(key_sel) < N_U);
  assign hold_load = (hold_len == '0) ? CNT_W'(1) : CNT_W'(hold_len);
  // Treating 0 like 1 means the counter is never decremented from 0.
  assign last      = (cnt_q <= CNT_W'(1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
    level   = 1'b1;
`ifdef KEY_PRESS_GEN_BOUNCE_EN
    lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    hold_d  = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          sel_d = key_sel;
`ifdef KEY_PRESS_GEN_BOUNCE_EN
          hold_d  = hold_load;
          state_d = BOUNCE_IN;
          cnt_d   = BOUNCE_LOAD;
`else
          state_d = HOLD;
          cnt_d   = hold_load;
`endif
        end
      end
`ifdef KEY_PRESS_GEN_BOUNCE_EN
      BOUNCE_IN: begin
        // Chatter, but settle low on the final cycle.
        level = last ? 1'b0 : lfsr_q[0];
        if (last) begin
          state_d = HOLD;
          cnt_d   = hold_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      HOLD: begin
        level = 1'b0;
        if (last) begin
`ifdef KEY_PRESS_GEN_BOUNCE_EN
          state_d = BOUNCE_OUT;
          cnt_d   = BOUNCE_LOAD;
`else
          state_d = GAP;
          cnt_d   = GAP_LOAD;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef KEY_PRESS_GEN_BOUNCE_EN
      BOUNCE_OUT: begin
        // Chatter, but settle high on the final cycle.
        level = last ? 1'b1 : lfsr_q[0];
        if (last) begin
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`endif
      GAP: begin
        if (last) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Only the selected line can ever leave the idle level.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_line
      assign key_out_d[gi] = (sel_q == SEL_W'(gi)) ? level : 1'b1;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      key_out_q <= '1;
      done_q    <= 1'b0;
`ifdef KEY_PRESS_GEN_BOUNCE_EN
      lfsr_q    <= 16'hACE1;
      hold_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      key_out_q <= key_out_d;
      done_q    <= done_d;
`ifdef KEY_PRESS_GEN_BOUNCE_EN
      lfsr_q    <= lfsr_d;
      hold_q    <= hold_d;
`endif
    end
  end

endmodule
